// File: rtl/rom_pkg.sv
// Shared types and constants for the 8x14 lookup ROM and its stream reader.
package rom_pkg;

  localparam int unsigned ROM_ADDR_W = 3;
  localparam int unsigned ROM_DATA_W = 14;
  localparam int unsigned ROM_DEPTH  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  typedef logic [ROM_ADDR_W-1:0] rom_addr_t;
  typedef logic [ROM_DATA_W-1:0] rom_word_t;

endpackage

// File: rtl/rom_stream_reader_if.sv
// Valid/ready word stream leaving the ROM reader, with a last-word qualifier.
interface rom_stream_reader_if #(
  parameter int unsigned DATA_W = 14
) ();

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/rom_stream_reader.sv
// Burst sequencer driving the combinational ROM address and streaming the
// registered ROM words out over a valid/ready interface.
module rom_stream_reader
  import rom_pkg::*;
#(
  parameter int unsigned ADDR_W = ROM_ADDR_W,
  parameter int unsigned DATA_W = ROM_DATA_W,
  parameter int unsigned DEPTH  = ROM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  output logic              busy,
  output logic              done,
  rom_stream_reader_if.master m
);

  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  rd_state_t         state, state_n;
  logic [ADDR_W:0]   remaining, remaining_n;
  logic [ADDR_W-1:0] addr_n;
  logic              valid_n, last_n, busy_n, done_n;
  logic [DATA_W-1:0] data_n;
  logic              load;

  // A new word may enter the output register when it is empty or being drained.
  assign load = !m.m_valid || m.m_ready;

  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    addr_n      = rom_addr;
    valid_n     = m.m_valid;
    data_n      = m.m_data;
    last_n      = m.m_last;
    busy_n      = busy;
    done_n      = 1'b0;

    unique case (state)
      IDLE: begin
        if (start && (count != '0)) begin
          addr_n      = start_addr;
          remaining_n = (count > MAX_LEN) ? MAX_LEN : count;
          busy_n      = 1'b1;
          state_n     = RUN;
        end
      end

      RUN: begin
        if (load) begin
          data_n      = rom_dout;
          valid_n     = 1'b1;
          last_n      = (remaining == ONE);
          remaining_n = remaining - ONE;
          // The address stays on the final word so it reflects the last read.
          if (remaining == ONE) begin
            state_n = DRAIN;
          end else begin
            addr_n = rom_addr + 1'b1;
          end
        end
      end

      DRAIN: begin
        if (m.m_valid && m.m_ready) begin
          valid_n = 1'b0;
          last_n  = 1'b0;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      rom_addr  <= '0;
      m.m_valid <= 1'b0;
      m.m_data  <= '0;
      m.m_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      rom_addr  <= addr_n;
      m.m_valid <= valid_n;
      m.m_data  <= data_n;
      m.m_last  <= last_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

// File: doc/rom_stream_reader.md
Name: rom_stream_reader

Overview:
Sequencer that sits directly upstream of the 8x14 lookup ROM and drives its address. On a start command it walks a burst of consecutive addresses, wrapping from 7 to 0. It registers each combinational ROM word and presents it on a valid/ready stream, with a last flag and a done pulse. It is the only master of the ROM address bus; the ROM stays combinational and file-initialised.

Parameters:
ADDR_W, 3, ROM address width.
DATA_W, 14, ROM word width.
DEPTH, 8, number of ROM words (2**ADDR_W).

Ports:
clk  in  1  single clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle burst request; sampled only in IDLE.
start_addr  in  ADDR_W  first ROM address of the burst.
count  in  ADDR_W+1  burst length in words. Legal range 1..8; 0 means no burst; values above 8 clamp to 8.
rom_addr  out  ADDR_W  address to the ROM, registered.
rom_dout  in  DATA_W  combinational ROM data for rom_addr.
m_valid  out  1  m_data holds a word.
m_ready  in  1  downstream accepts the word when m_valid is 1 at this edge.
m_data  out  DATA_W  registered ROM word.
m_last  out  1  qualifies the final word of the burst.
busy  out  1  high from the cycle after start until done.
done  out  1  one-cycle pulse after the last handshake.

Behaviour:
- Reset values: rom_addr=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0; FSM in IDLE; remaining=0.
- States: IDLE, RUN, DRAIN.
- IDLE, start=1 and count!=0:
  - rom_addr<=start_addr.
  - remaining<=min(count,8).
  - busy<=1, go to RUN.
- IDLE, start=1 and count=0: ignored. No busy, no done.
- start while busy: ignored, with no queueing.
- RUN, load condition = (!m_valid || m_ready). On each load:
  - m_data<=rom_dout, m_valid<=1.
  - m_last<=(remaining==1).
  - remaining<=remaining-1.
  - rom_addr<=rom_addr+1, modulo DEPTH (7 wraps to 0).
- RUN, load with remaining==1: go to DRAIN; rom_addr is not advanced.
- RUN without the load condition: everything holds, and m_data must not change while m_valid=1 and m_ready=0.
- DRAIN, m_valid and m_ready:
  - m_valid<=0, m_last<=0.
  - done<=1 for one cycle, busy<=0.
  - go to IDLE.
- Latency: first m_valid rises 2 cycles after the start edge (start sampled at N, RUN at N+1, m_valid at N+2).
- Throughput: one word per cycle while m_ready=1; a burst of L words with m_ready tied high takes L+2 cycles from start to done.
- Backpressure: m_ready may toggle arbitrarily. Words are never dropped, duplicated or reordered.
- m_ready while m_valid=0 has no effect.
- rst mid-burst: every output returns to its reset value on the next edge; no done pulse; the partial burst is discarded.
- A start in the same cycle as the done pulse is accepted, because the FSM is already in IDLE.

Decomposition:
- Shared package rom_pkg:
  - localparams ROM_ADDR_W=3, ROM_DATA_W=14, ROM_DEPTH=8.
  - typedef enum logic [1:0] rd_state_t {IDLE, RUN, DRAIN}.
  - typedefs rom_addr_t and rom_word_t.
- No sub-module is required; the output register stays inline.
- The testbench instantiates rom_stream_reader with the existing ROM block. The ROM data file is loaded with mem[i]=i*14'h111, i.e. 000, 111, 222 … 777.

Test Plan:
1. Reset, then start with start_addr=0, count=8, m_ready=1 -> m_data sequence 000,111,…,777 on consecutive cycles; m_last only on 777; done at cycle N+10.
2. start_addr=6, count=4, m_ready=1 -> data 666,777,000,111 (wrap); rom_addr returns to 1 and holds; one done pulse.
3. count=3, start_addr=2, with m_ready low on alternate cycles -> data 222,333,444 each held stable while stalled; no loss or duplicates; m_last on 444.
4. count=0 -> busy, m_valid and done stay 0. Then count=12 -> exactly 8 words are delivered.
5. start pulsed again mid-burst -> ignored; the original burst completes unchanged.
6. rst asserted after the 2nd word of an 8-word burst -> next cycle m_valid=0, busy=0, rom_addr=0, no done. A fresh start afterwards runs correctly.
